// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: turns a valid/ready command stream
// into one bus cycle at a time and returns read data plus a timeout flag.
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_W       = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [3:0]          cmd_sel_i,
  input  logic [31:0]         cmd_adr_i,
  input  logic [31:0]         cmd_dat_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic [31:0]         wbm_adr_o,
  output logic [31:0]         wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [31:0]         wbm_dat_i,
  output logic                busy_o,
  output logic [TO_CNT_W-1:0] to_count_o
);

  // state | meaning
  // IDLE  | ready for a command, bus idle
  // BUS   | cyc/stb asserted, waiting for ack or timeout
  // RESP  | response held on rsp_* until consumed
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds the number of ack-less cycles already completed, so the
  // abort fires on the edge that ends the TIMEOUT_CYCLES-th stb cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit;

  assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LAST);
  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
      to_count_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o  <= cmd_we_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wait_cnt  <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (timeout_hit) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= 32'h0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            if (to_count_o != {TO_CNT_W{1'b1}}) begin
              to_count_o <= to_count_o + 1'b1;
            end
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: directed bring-up scenarios followed by
// randomized traffic against a behavioural slave and response model.
module tb_wb_cmd_master;
  localparam int TO = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [3:0]  cmd_sel_i = '0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;
  logic        busy_o;
  logic [7:0]  to_count_o;

  wb_cmd_master #(.TIMEOUT_CYCLES(TO), .TO_CNT_W(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_sel_i(cmd_sel_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy_o(busy_o), .to_count_o(to_count_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          stb;
    logic [7:0]  to_cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passed = 0;
  int          stb_cyc = 0;
  int          ack_at = 0;
  logic [31:0] rd_data = '0;
  logic        stray = 1'b0;
  logic        rnd_rdy = 1'b0;
  logic [7:0]  model_to = '0;
  logic        cur_we = 1'b0;
  logic [3:0]  cur_sel = '0;
  logic [31:0] cur_adr = '0, cur_dat = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endfunction

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Slave: acks on the ack_at-th stb cycle of the transaction (0 = never).
  always @(negedge wb_clk_i) begin
    if (wb_rst_ni && wbm_cyc_o && wbm_stb_o) begin
      stb_cyc++;
      chk1("bus_we", wbm_we_o, cur_we);
      chk("bus_sel", 32'(wbm_sel_o), 32'(cur_sel));
      chk("bus_adr", wbm_adr_o, cur_adr);
      chk("bus_dat", wbm_dat_o, cur_dat);
      wbm_ack_i = (stb_cyc == ack_at) || stray;
      wbm_dat_i = (stb_cyc == ack_at) ? rd_data : $urandom();
    end else begin
      wbm_ack_i = stray;
      wbm_dat_i = $urandom();
    end
  end

  always @(negedge wb_clk_i) begin : monitor
    exp_t e;
    if (wb_rst_ni && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        chk1("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_dat", rsp_dat_o, e.dat);
        chk1("rsp_err", rsp_err_o, e.err);
        chk("stb_cycles", 32'(stb_cyc), 32'(e.stb));
        chk("to_count", 32'(to_count_o), 32'(e.to_cnt));
      end
    end
  end

  always @(posedge wb_clk_i) begin
    #1;
    if (rnd_rdy) rsp_ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, input int ack_n, input logic [31:0] rdd);
    int          n;
    exp_t        e;
    logic        tmo;
    logic [31:0] r;
    n = 0;
    cmd_we_i = we; cmd_sel_i = sel; cmd_adr_i = adr; cmd_dat_i = dat;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && n < 100) begin tick(); n++; end
    if (!cmd_ready_o) begin
      chk1("accept_wait", 1'b0, 1'b1);
      cmd_valid_i = 1'b0;
      return;
    end
    tick();
    r = $urandom();
    cmd_valid_i = 1'b0;
    cmd_we_i = r[0]; cmd_sel_i = r[7:4]; cmd_adr_i = $urandom(); cmd_dat_i = $urandom();
    cur_we = we; cur_sel = sel; cur_adr = adr; cur_dat = dat;
    stb_cyc = 0; ack_at = ack_n; rd_data = rdd;
    tmo = (ack_n == 0) || (ack_n > TO);
    if (tmo && model_to != 8'hFF) model_to++;
    e.dat = (tmo || we) ? 32'h0 : rdd;
    e.err = tmo;
    e.stb = tmo ? TO : ack_n;
    e.to_cnt = model_to;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] r;

    #1 wb_rst_ni = 1'b0;
    #3;
    chk1("rst_cyc", wbm_cyc_o, 1'b0);
    chk1("rst_stb", wbm_stb_o, 1'b0);
    chk1("rst_we", wbm_we_o, 1'b0);
    chk("rst_sel", 32'(wbm_sel_o), 32'h0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_wdat", wbm_dat_o, 32'h0);
    chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk1("rst_rsp_err", rsp_err_o, 1'b0);
    chk("rst_rsp_dat", rsp_dat_o, 32'h0);
    chk1("rst_busy", busy_o, 1'b0);
    chk("rst_to_count", 32'(to_count_o), 32'h0);
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;
    tick();
    chk1("ready_after_reset", cmd_ready_o, 1'b1);

    // Zero-wait write: minimum latency path.
    rsp_ready_i = 1'b1;
    issue(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_1234, 1, 32'h0);
    chk1("wr_cyc_t1", wbm_cyc_o, 1'b1);
    chk1("wr_stb_t1", wbm_stb_o, 1'b1);
    chk1("wr_busy_t1", busy_o, 1'b1);
    tick();
    chk1("wr_rsp_valid_t2", rsp_valid_o, 1'b1);
    chk1("wr_stb_t2", wbm_stb_o, 1'b0);
    tick();
    chk1("wr_ready_t3", cmd_ready_o, 1'b1);

    // Read with 3 wait states (ack on the 4th stb cycle, which also ties with
    // the timeout) followed by 10 cycles of response backpressure.
    rsp_ready_i = 1'b0;
    issue(1'b0, 4'h3, 32'h3000_0010, 32'h0, 4, 32'hCAFE_0001);
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      chk1("rd_ready_in_bus", cmd_ready_o, 1'b0);
      tick(); n++;
    end
    chk1("rd_rsp_seen", rsp_valid_o, 1'b1);
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stray = (i >= 3 && i < 6);
      chk1("bp_valid", rsp_valid_o, 1'b1);
      chk("bp_dat", rsp_dat_o, 32'hCAFE_0001);
      chk1("bp_err", rsp_err_o, 1'b0);
      chk1("bp_cmd_ready", cmd_ready_o, 1'b0);
      tick();
    end
    stray = 1'b0;
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    chk1("bp_idle_busy", busy_o, 1'b0);
    chk1("bp_idle_valid", rsp_valid_o, 1'b0);
    chk1("bp_idle_ready", cmd_ready_o, 1'b1);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'h0);

    // Stray ack while idle.
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("idle_stray_valid", rsp_valid_o, 1'b0);
      chk1("idle_stray_busy", busy_o, 1'b0);
      chk("idle_stray_dat", rsp_dat_o, 32'hCAFE_0001);
    end
    stray = 1'b0;
    tick();

    // Timeout: slave never acks.
    issue(1'b0, 4'hF, 32'h3000_0020, 32'h0, 0, 32'h0);
    drain();
    chk("timeout_to_count", 32'(to_count_o), 32'h1);

    // Async reset in the middle of a bus cycle.
    issue(1'b0, 4'hF, 32'h3000_0030, 32'h0, 0, 32'h0);
    tick();
    chk1("pre_rst_stb", wbm_stb_o, 1'b1);
    #2 wb_rst_ni = 1'b0;
    #1;
    chk1("async_rst_cyc", wbm_cyc_o, 1'b0);
    chk1("async_rst_stb", wbm_stb_o, 1'b0);
    chk1("async_rst_valid", rsp_valid_o, 1'b0);
    chk1("async_rst_busy", busy_o, 1'b0);
    exp_q.delete();
    model_to = '0;
    @(posedge wb_clk_i);
    #3 wb_rst_ni = 1'b1;
    tick();
    chk1("ready_after_async_rst", cmd_ready_o, 1'b1);
    issue(1'b0, 4'h1, 32'h3000_0040, 32'h0, 2, 32'h1234_5678);
    drain();

    // Randomized traffic with random response backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom();
      issue(r[0], r[7:4], $urandom(), $urandom(), $urandom_range(0, 6), $urandom());
    end
    drain();
    rnd_rdy = 1'b0;
    rsp_ready_i = 1'b1;
    drain();
    chk("final_to_count", 32'(to_count_o), 32'(model_to));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic single-transfer initiator, i.e. the master end of the slave interface the user project exposes.
- Converts a valid/ready command stream into one Wishbone read or write cycle at a time, and returns read data plus an error flag on a valid/ready response stream.
- Used by test and bring-up logic, for example logic-analyzer-driven sequencing, to drive the ldpcEncDec register/data port.
- Provides a bus timeout so a non-responding slave cannot hang the initiator.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles with stb asserted before abort; 0 disables the timeout.
- TO_CNT_W, 8: width of the saturating timeout-event counter.

Ports:
- wb_clk_i  in  1  single clock; every flop is on its rising edge.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_sel_i  in  4  byte selects.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  32  read data; 0 for writes and for timeouts.
- rsp_err_o  out  1  1 = timeout abort.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte selects.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_ack_i  in  1  Wishbone acknowledge from the slave.
- wbm_dat_i  in  32  Wishbone read data from the slave.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- to_count_o  out  TO_CNT_W  number of timeouts, saturating.

Behaviour:
- Reset (wb_rst_ni low): asynchronous; takes effect immediately, even mid-cycle.
  - All outputs go to 0: cyc, stb, we, sel, adr, dat, rsp_valid, rsp_err, rsp_dat, busy, to_count.
  - FSM goes to IDLE.
  - After release, cmd_ready_o is 1.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On a rising edge with cmd_valid_i high: latch we/sel/adr/dat into the wbm_* registers, set cyc = stb = 1, clear the wait counter, go to BUS.
  - cyc/stb are therefore visible in the cycle after acceptance.
- BUS:
  - cmd_ready_o = 0.
  - cyc, stb and all wbm_* outputs are held stable.
  - Wait counter increments each cycle that wbm_ack_i is low.
  - Ack sampled high:
    - cyc = stb = 0 on the next cycle.
    - rsp_dat_o = wbm_dat_i for reads, 0 for writes.
    - rsp_err_o = 0, rsp_valid_o = 1, go to RESP.
  - Timeout (TIMEOUT_CYCLES ≠ 0, counter reaches TIMEOUT_CYCLES with ack still low):
    - cyc = stb = 0, rsp_err_o = 1, rsp_dat_o = 0, rsp_valid_o = 1.
    - to_count_o increments, saturating at 2^TO_CNT_W−1.
    - Go to RESP.
  - Ack arriving in the same cycle as the timeout condition: ack wins; no error and no count.
- RESP:
  - rsp_valid_o and the response data are held until rsp_ready_i is sampled high.
  - Then rsp_valid_o = 0, go to IDLE.
  - cmd_ready_o = 0 throughout RESP; no overlap, at most one outstanding transaction.
- wbm_ack_i in IDLE or RESP is ignored: no state change, no data capture.
- wbm_we/sel/adr/dat keep their last values after the cycle ends. Only cyc/stb carry the protocol.
- Minimum latency, with t0 = command accept edge:
  - cyc/stb high during t0+1.
  - Zero-wait ack at t0+1 gives rsp_valid_o high at t0+2.
  - With rsp_ready_i tied high, the next command is accepted at t0+3 at the earliest.
- cmd_* inputs are don't-care when cmd_ready_o is low.
- busy_o = (state ≠ IDLE).

Test Plan:
- Write: cmd we=1, sel=4'hF, adr=32'h3000_0004, dat=32'hA5A5_1234; slave acks on its 1st stb cycle -> wbm bus shows those values for exactly 1 stb cycle; rsp_valid at t0+2 with rsp_err=0 and rsp_dat=0.
- Read with 3 wait states: slave returns 32'hCAFE_0001 -> stb high for 4 cycles; rsp_dat=32'hCAFE_0001; cmd_ready stays 0 until the response is consumed.
- Backpressure: rsp_ready held low for 10 cycles -> rsp_valid and data stable for all 10; no new command accepted; IDLE entered the cycle after rsp_ready=1.
- Timeout: TIMEOUT_CYCLES=4, slave never acks -> stb high for 4 cycles then drops; rsp_err=1, rsp_dat=0, to_count increments by 1; ack arriving on the 4th cycle -> rsp_err=0 and to_count unchanged.
- Async reset asserted mid-BUS -> cyc/stb/rsp_valid go to 0 without waiting for a clock edge; after release cmd_ready=1 and a subsequent read completes normally.
- Stray ack while in IDLE and in RESP -> no response generated, rsp_dat unchanged.
